e203_tb_irq_stim_mon: RTL and testbench

//  Parametrised commit monitor and interrupt stimulus engine for E203 simulation benches.

---
 rtl/e203_tb_irq_stim_mon_pkg.sv | 27 ++
 rtl/e203_tb_irq_stim_mon_chan.sv | 89 ++++++++
 rtl/e203_tb_irq_stim_mon.sv | 141 ++++++++++++++
 tb/tb_e203_tb_irq_stim_mon.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_tb_irq_stim_mon_pkg.sv
// Shared types and helpers for the E203 interrupt stimulus / commit monitor.
// Holds the per-channel state encoding and the 16-bit Fibonacci LFSR step.
// The tap positions are written 1-based (x^16 + x^14 + x^13 + x^11 + 1).
package e203_tb_irq_stim_mon_pkg;

  // Per-channel interrupt generator state.
  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_DELAY  = 2'd1,
    CH_ASSERT = 2'd2,
    CH_STOP   = 2'd3
  } chan_state_e;

  localparam int unsigned LFSR_W     = 16;
  localparam int unsigned LFSR_TAP_A = 16;
  localparam int unsigned LFSR_TAP_B = 14;
  localparam int unsigned LFSR_TAP_C = 13;
  localparam int unsigned LFSR_TAP_D = 11;

  // One Fibonacci step: shift left, feed the XOR of the tap bits into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic fb;
    fb = s[LFSR_TAP_A-1] ^ s[LFSR_TAP_B-1] ^ s[LFSR_TAP_C-1] ^ s[LFSR_TAP_D-1];
    return {s[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/e203_tb_irq_stim_mon_chan.sv
// One interrupt channel: free-running LFSR, random gap counter and IDLE/DELAY/ASSERT/STOP FSM.
// irq_o is registered: it rises on the edge that enters ASSERT and falls on the edge after the handler exit.
// No backpressure; arm/handler events are single-cycle pulses decoded by the top.
module e203_tb_irq_stim_mon_chan
  import e203_tb_irq_stim_mon_pkg::*;
#(
  parameter int unsigned       DLY_LOG2 = 10,
  parameter logic [LFSR_W-1:0] SEED     = 16'hACE1
) (
  input  logic hfclk,
  input  logic rst_n,
  input  logic en_i,
  input  logic arm_i,
  input  logic hdl_hit_i,
  input  logic past_stop_i,
  output logic irq_o
);

  // One spare bit so lfsr[DLY_LOG2-1:0]+1 (up to 2**DLY_LOG2) never overflows.
  localparam int unsigned DLY_W = DLY_LOG2 + 1;

  logic [LFSR_W-1:0] lfsr_q;
  chan_state_e       state_q;
  logic [DLY_W-1:0]  dly_q;
  logic [DLY_W-1:0]  dly_load;
  logic              irq_q;

  // Gap length for the next assertion: 1 .. 2**DLY_LOG2 cycles.
  assign dly_load = {1'b0, lfsr_q[DLY_LOG2-1:0]} + DLY_W'(1);

  // LFSR steps every cycle regardless of channel state or enable.
  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  // Channel FSM with registered interrupt output; disable forces IDLE.
  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_IDLE;
      dly_q   <= '0;
      irq_q   <= 1'b0;
    end else if (!en_i) begin
      state_q <= CH_IDLE;
      irq_q   <= 1'b0;
    end else begin
      case (state_q)
        CH_IDLE: begin
          if (arm_i) begin
            state_q <= CH_DELAY;
            dly_q   <= dly_load;
          end
        end
        CH_DELAY: begin
          if (dly_q == DLY_W'(1)) begin
            state_q <= CH_ASSERT;
            irq_q   <= 1'b1;
          end else begin
            dly_q <= dly_q - DLY_W'(1);
          end
        end
        CH_ASSERT: begin
          if (hdl_hit_i) begin
            irq_q <= 1'b0;
            if (past_stop_i) begin
              state_q <= CH_STOP;
            end else begin
              state_q <= CH_DELAY;
              dly_q   <= dly_load;
            end
          end
        end
        CH_STOP: begin
          irq_q <= 1'b0;
        end
        default: begin
          state_q <= CH_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/e203_tb_irq_stim_mon.sv
// Commit monitor + interrupt stimulus for E203 benches: statistics counters, done/pass/timeout, N_IRQ channels.
// All outputs registered; counters update one cycle after the sampled event and saturate at all-ones.
// Pure observer on the commit/EXU nets: never stalls the core, every commit pulse is consumed the cycle it appears.
module e203_tb_irq_stim_mon
  import e203_tb_irq_stim_mon_pkg::*;
#(
  parameter int unsigned             PC_W       = 32,
  parameter int unsigned             XLEN       = 32,
  parameter int unsigned             CNT_W      = 32,
  parameter int unsigned             N_IRQ      = 3,
  parameter int unsigned             DLY_LOG2   = 10,
  parameter int unsigned             END_CNT    = 8,
  parameter int unsigned             STOP_CNT   = 32,
  parameter int unsigned             TIMEOUT    = 10000000,
  parameter logic [PC_W-1:0]         ARM_PC     = 32'h8000015C,
  parameter logic [PC_W-1:0]         TOHOST_PC  = 32'h80000086,
  parameter logic [N_IRQ*PC_W-1:0]   HANDLER_PC = {N_IRQ{32'h80000100}},
  parameter logic [LFSR_W-1:0]       LFSR_SEED  = 16'hACE1
) (
  input  logic             hfclk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cmt_valid,
  input  logic [PC_W-1:0]  cmt_pc,
  input  logic             exu_i_vld,
  input  logic             exu_i_rdy,
  input  logic [XLEN-1:0]  x3_val,
  output logic [N_IRQ-1:0] irq_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] tohost_cnt,
  output logic [CNT_W-1:0] end_cycle,
  output logic             done,
  output logic             pass,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] END_C   = CNT_W'(END_CNT);
  localparam logic [CNT_W-1:0] STOP_C  = CNT_W'(STOP_CNT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic             hit_th;
  logic             arm_hit;
  logic             past_stop;
  logic [N_IRQ-1:0] irq_w;

  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] tohost_cnt_q, tohost_cnt_d;
  logic [CNT_W-1:0] end_cycle_q, end_cycle_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic             done_set;
  logic             timeout_set;

  assign hit_th    = cmt_valid && (cmt_pc == TOHOST_PC);
  assign arm_hit   = cmt_valid && (cmt_pc == ARM_PC);
  // Registered tohost count decides STOP vs re-arm at a handler exit.
  assign past_stop = (tohost_cnt_q > STOP_C);

  // Statistic counters: all saturate; instr_cnt freezes from the first tohost cycle on.
  always_comb begin
    cycle_cnt_d  = cycle_cnt_q;
    instr_cnt_d  = instr_cnt_q;
    tohost_cnt_d = tohost_cnt_q;
    end_cycle_d  = end_cycle_q;
    if (cycle_cnt_q != CNT_MAX) begin
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    end
    if (hit_th && (tohost_cnt_q != CNT_MAX)) begin
      tohost_cnt_d = tohost_cnt_q + CNT_W'(1);
    end
    if (hit_th && (tohost_cnt_q == '0)) begin
      end_cycle_d = cycle_cnt_q;
    end
    if (exu_i_vld && exu_i_rdy && !hit_th && (tohost_cnt_q == '0) &&
        (instr_cnt_q != CNT_MAX)) begin
      instr_cnt_d = instr_cnt_q + CNT_W'(1);
    end
  end

  // End-of-test flags: done wins over timeout if both would fire together; both sticky.
  always_comb begin
    done_set    = !done_q && !timeout_q && (tohost_cnt_q >= END_C) && (irq_w == '0);
    timeout_set = !timeout_q && !done_q && !done_set && (cycle_cnt_d == TO_LAST);
    done_d      = done_q | done_set;
    pass_d      = done_set ? (x3_val == XLEN'(1)) : pass_q;
    timeout_d   = timeout_q | timeout_set;
  end

  // Register all monitor state.
  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
      tohost_cnt_q <= '0;
      end_cycle_q  <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
      tohost_cnt_q <= tohost_cnt_d;
      end_cycle_q  <= end_cycle_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
    end
  end

  for (genvar ch = 0; ch < N_IRQ; ch++) begin : g_chan
    logic hdl_hit;
    assign hdl_hit = cmt_valid && (cmt_pc == HANDLER_PC[ch*PC_W +: PC_W]);

    e203_tb_irq_stim_mon_chan #(
      .DLY_LOG2 (DLY_LOG2),
      .SEED     (LFSR_SEED ^ LFSR_W'(ch + 1))
    ) u_chan (
      .hfclk       (hfclk),
      .rst_n       (rst_n),
      .en_i        (en),
      .arm_i       (arm_hit),
      .hdl_hit_i   (hdl_hit),
      .past_stop_i (past_stop),
      .irq_o       (irq_w[ch])
    );
  end

  assign irq_o      = irq_w;
  assign cycle_cnt  = cycle_cnt_q;
  assign instr_cnt  = instr_cnt_q;
  assign tohost_cnt = tohost_cnt_q;
  assign end_cycle  = end_cycle_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_e203_tb_irq_stim_mon.sv
// Directed bench for e203_tb_irq_stim_mon: counters, done/pass, timeout, interrupt timing and async reset.
// Interrupt edges are predicted from an independent LFSR model and queued per channel when stimulus is driven.
// A second instance with TIMEOUT=100 shares the inputs to exercise the timeout path.
module tb_e203_tb_irq_stim_mon;

  localparam int          N_IRQ = 3;
  localparam logic [31:0] ARM   = 32'h8000015C;
  localparam logic [31:0] TH    = 32'h80000086;
  localparam logic [95:0] HPC   = {32'h80000300, 32'h80000200, 32'h80000100};
  localparam logic [15:0] SEED  = 16'hACE1;

  logic              hfclk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              cmt_valid = 1'b0;
  logic [31:0]       cmt_pc = '0;
  logic              exu_i_vld = 1'b0;
  logic              exu_i_rdy = 1'b0;
  logic [31:0]       x3_val = '0;

  logic [N_IRQ-1:0]  irq_o;
  logic [31:0]       cycle_cnt, instr_cnt, tohost_cnt, end_cycle;
  logic              done, pass, timeout;

  logic [N_IRQ-1:0]  t_irq;
  logic [31:0]       t_cyc, t_instr, t_th, t_end;
  logic              t_done, t_pass, t_timeout;

  int checks = 0;
  int failures = 0;
  int exp_cyc = 0;
  int th_first = 0;
  logic [N_IRQ-1:0] prev_irq = '0;
  int rise_q [N_IRQ][$];
  int fall_q [N_IRQ][$];
  logic [15:0] mlfsr [N_IRQ];

  always #5 hfclk = ~hfclk;

  e203_tb_irq_stim_mon #(
    .DLY_LOG2 (2), .END_CNT (8), .STOP_CNT (32), .TIMEOUT (100000),
    .ARM_PC (ARM), .TOHOST_PC (TH), .HANDLER_PC (HPC), .LFSR_SEED (SEED)
  ) dut (
    .hfclk (hfclk), .rst_n (rst_n), .en (en), .cmt_valid (cmt_valid), .cmt_pc (cmt_pc),
    .exu_i_vld (exu_i_vld), .exu_i_rdy (exu_i_rdy), .x3_val (x3_val),
    .irq_o (irq_o), .cycle_cnt (cycle_cnt), .instr_cnt (instr_cnt), .tohost_cnt (tohost_cnt),
    .end_cycle (end_cycle), .done (done), .pass (pass), .timeout (timeout)
  );

  e203_tb_irq_stim_mon #(
    .DLY_LOG2 (2), .END_CNT (8), .STOP_CNT (32), .TIMEOUT (100),
    .ARM_PC (ARM), .TOHOST_PC (TH), .HANDLER_PC (HPC), .LFSR_SEED (SEED)
  ) dut_to (
    .hfclk (hfclk), .rst_n (rst_n), .en (en), .cmt_valid (cmt_valid), .cmt_pc (cmt_pc),
    .exu_i_vld (exu_i_vld), .exu_i_rdy (exu_i_rdy), .x3_val (x3_val),
    .irq_o (t_irq), .cycle_cnt (t_cyc), .instr_cnt (t_instr), .tohost_cnt (t_th),
    .end_cycle (t_end), .done (t_done), .pass (t_pass), .timeout (t_timeout)
  );

  // Reference LFSR: x^16+x^14+x^13+x^11, shift toward the MSB, feedback into bit 0.
  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  // Reference LFSR state per channel, seeded while reset is low.
  always @(posedge hfclk or negedge rst_n) begin
    for (int c = 0; c < N_IRQ; c++) begin
      if (!rst_n) mlfsr[c] <= SEED ^ 16'(c + 1);
      else        mlfsr[c] <= ref_step(mlfsr[c]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Compare every interrupt edge with the queued prediction.
  task automatic mon_irq();
    for (int c = 0; c < N_IRQ; c++) begin
      if (irq_o[c] && !prev_irq[c]) begin
        if (rise_q[c].size() == 0) begin
          chk($sformatf("irq%0d_unexpected_rise", c), 64'(irq_o[c]), 64'd0);
        end else begin
          int e;
          e = rise_q[c].pop_front();
          chk($sformatf("irq%0d_rise_cycle", c), 64'(exp_cyc), 64'(e));
        end
      end else if (!irq_o[c] && prev_irq[c]) begin
        if (fall_q[c].size() == 0) begin
          chk($sformatf("irq%0d_unexpected_fall", c), 64'(irq_o[c]), 64'd1);
        end else begin
          int e;
          e = fall_q[c].pop_front();
          chk($sformatf("irq%0d_fall_cycle", c), 64'(exp_cyc), 64'(e));
        end
      end
    end
    prev_irq = irq_o;
  endtask

  task automatic tick();
    @(posedge hfclk);
    exp_cyc++;
    @(negedge hfclk);
    mon_irq();
  endtask

  task automatic check_queues_empty(input string tag);
    for (int c = 0; c < N_IRQ; c++) begin
      chk($sformatf("%s_pending_ch%0d", tag, c), 64'(rise_q[c].size() + fall_q[c].size()), 64'd0);
    end
  endtask

  // Async reset mid-cycle; outputs must clear before any clock edge.
  task automatic apply_reset(input string tag);
    @(negedge hfclk);
    #2;
    rst_n = 1'b0;
    cmt_valid = 1'b0;
    exu_i_vld = 1'b0;
    exu_i_rdy = 1'b0;
    #1;
    chk({tag, "_rst_irq"}, 64'(irq_o), 64'd0);
    chk({tag, "_rst_cycle"}, 64'(cycle_cnt), 64'd0);
    chk({tag, "_rst_tohost"}, 64'(tohost_cnt), 64'd0);
    chk({tag, "_rst_instr"}, 64'(instr_cnt), 64'd0);
    chk({tag, "_rst_end"}, 64'(end_cycle), 64'd0);
    chk({tag, "_rst_flags"}, 64'({done, pass, timeout}), 64'd0);
    repeat (2) @(negedge hfclk);
    rst_n = 1'b1;
    exp_cyc = 0;
    prev_irq = '0;
    for (int c = 0; c < N_IRQ; c++) begin
      rise_q[c].delete();
      fall_q[c].delete();
    end
  endtask

  task automatic arm_all();
    cmt_valid = 1'b1;
    cmt_pc = ARM;
    for (int c = 0; c < N_IRQ; c++) begin
      rise_q[c].push_back(exp_cyc + 2 + int'(mlfsr[c][1:0]));
    end
    tick();
    cmt_valid = 1'b0;
  endtask

  task automatic retire_handler(input int c, input bit to_stop, input bit in_assert);
    logic [95:0] tab;
    tab = HPC;
    cmt_valid = 1'b1;
    cmt_pc = tab[c*32 +: 32];
    if (in_assert) begin
      fall_q[c].push_back(exp_cyc + 1);
      if (!to_stop) rise_q[c].push_back(exp_cyc + 2 + int'(mlfsr[c][1:0]));
    end
    tick();
    cmt_valid = 1'b0;
  endtask

  task automatic wait_all_high(input string tag);
    for (int i = 0; i < 8 && irq_o !== 3'b111; i++) tick();
    chk(tag, 64'(irq_o), 64'h7);
  endtask

  task automatic retire_tohost(input int n);
    cmt_valid = 1'b1;
    cmt_pc = TH;
    repeat (n) tick();
    cmt_valid = 1'b0;
  endtask

  initial begin
    // Reset state.
    apply_reset("init");
    chk("init_cycle_before_edge", 64'(cycle_cnt), 64'd0);

    // T1: en=0, arm ignored, 8 tohost retirements -> done/pass, counters.
    en = 1'b0;
    x3_val = 32'd1;
    cmt_valid = 1'b1; cmt_pc = ARM;
    tick();
    cmt_valid = 1'b0;
    chk("t1_cycle_cnt", 64'(cycle_cnt), 64'(exp_cyc));
    exu_i_vld = 1'b1; exu_i_rdy = 1'b0;
    tick();
    exu_i_rdy = 1'b1;
    repeat (5) tick();
    chk("t1_instr_cnt", 64'(instr_cnt), 64'd5);
    th_first = exp_cyc;
    retire_tohost(8);
    exu_i_vld = 1'b0; exu_i_rdy = 1'b0;
    chk("t1_tohost_cnt", 64'(tohost_cnt), 64'd8);
    chk("t1_instr_frozen", 64'(instr_cnt), 64'd5);
    chk("t1_end_cycle", 64'(end_cycle), 64'(th_first));
    chk("t1_done_not_yet", 64'(done), 64'd0);
    tick();
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_pass", 64'(pass), 64'd1);
    chk("t1_irq_quiet", 64'(irq_o), 64'd0);
    chk("t1_cycle_cnt_end", 64'(cycle_cnt), 64'(exp_cyc));

    // T5: timeout instance flags at cycle 99; x3=5 at done gives pass=0.
    apply_reset("t5");
    en = 1'b0;
    x3_val = 32'd5;
    while (exp_cyc < 98) tick();
    chk("t5_cyc98", 64'(t_cyc), 64'd98);
    chk("t5_timeout_before", 64'(t_timeout), 64'd0);
    tick();
    chk("t5_cyc99", 64'(t_cyc), 64'd99);
    chk("t5_timeout_at_99", 64'(t_timeout), 64'd1);
    chk("t5_main_no_timeout", 64'(timeout), 64'd0);
    th_first = exp_cyc;
    retire_tohost(8);
    tick();
    chk("t5_main_done", 64'(done), 64'd1);
    chk("t5_main_pass_x3_5", 64'(pass), 64'd0);
    chk("t5_to_done_blocked", 64'(t_done), 64'd0);
    chk("t5_to_timeout_held", 64'(t_timeout), 64'd1);
    chk("t5_to_pass", 64'(t_pass), 64'd0);
    chk("t5_to_tohost", 64'(t_th), 64'd8);
    chk("t5_to_end_cycle", 64'(t_end), 64'(th_first));
    chk("t5_to_instr", 64'(t_instr), 64'd0);
    chk("t5_to_irq", 64'(t_irq), 64'd0);

    // T2: arm -> every channel asserts after its LFSR gap.
    apply_reset("t2");
    en = 1'b1;
    x3_val = 32'd1;
    arm_all();
    wait_all_high("t2_all_high");
    cmt_valid = 1'b1; cmt_pc = ARM;   // arm outside IDLE: ignored
    tick();
    cmt_valid = 1'b0;
    tick();
    chk("t2_hold", 64'(irq_o), 64'h7);

    // T3: handler 1 clears only ch1; repeat while in DELAY is ignored.
    retire_handler(1, 1'b0, 1'b1);
    chk("t3_ch1_low", 64'(irq_o[1]), 64'd0);
    chk("t3_ch0_ch2_high", 64'({irq_o[2], irq_o[0]}), 64'h3);
    retire_handler(1, 1'b0, 1'b0);
    wait_all_high("t3_ch1_rearmed");
    check_queues_empty("t3");

    // T4: past STOP_CNT a handler exit parks the channel; done waits for all irq low.
    retire_tohost(33);
    chk("t4_tohost_33", 64'(tohost_cnt), 64'd33);
    chk("t4_done_blocked", 64'(done), 64'd0);
    retire_handler(0, 1'b1, 1'b1);
    chk("t4_done_wait_ch12", 64'(done), 64'd0);
    retire_handler(1, 1'b1, 1'b1);
    retire_handler(2, 1'b1, 1'b1);
    chk("t4_irq_all_low", 64'(irq_o), 64'd0);
    chk("t4_done_one_later", 64'(done), 64'd0);
    tick();
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_pass", 64'(pass), 64'd1);
    repeat (6) tick();
    chk("t4_stop_quiet", 64'(irq_o), 64'd0);
    check_queues_empty("t4");

    // en=0 drops STOP channels to IDLE; a fresh arm restarts them.
    en = 1'b0;
    tick();
    en = 1'b1;
    arm_all();
    wait_all_high("en_rearm_all_high");

    // T6: async reset while all irq are high; counters restart.
    apply_reset("t6");
    tick();
    chk("t6_cycle_restart", 64'(cycle_cnt), 64'd1);
    chk("t6_tohost_restart", 64'(tohost_cnt), 64'd0);
    chk("t6_irq_idle", 64'(irq_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
